// File: rtl/pixel_array_controller_pkg.sv
// Shared pixel-array configuration: geometry, ramp width
// and the frame sequencer state encoding.
package PixelSensorConfig;

   localparam int PIXEL_ARRAY_HEIGHT = 2;
   localparam int PIXEL_BITS         = 10;
   localparam int RAMP_BITS          = 8;

   typedef enum logic [2:0] {
      IDLE,
      ERASE,
      EXPOSE,
      CONVERT,
      READOUT
   } ctrl_state_t;

endpackage

// File: rtl/pixel_array_controller_phase_timer.sv
// Loadable down-counter timing the ERASE, EXPOSE and CONVERT
// phases; tc flags the last cycle of a phase.
module phase_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] count_next,
   output logic             tc
);

   always_comb begin
      count_next = count;
      if (load)
         count_next = load_val;
      else if (count != '0)
         count_next = count - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else
         count <= count_next;
   end

   assign tc = (count == '0);

endmodule

// File: rtl/pixel_array_controller.sv
// Frame sequencer: erase, expose, ramp conversion, then
// row-by-row readout over a valid/ready handshake.
module pixel_array_controller #(
   parameter int ERASE_CYCLES = 5,
   parameter int EXPOSE_BITS  = 8,
   parameter int RAMP_BITS    = PixelSensorConfig::RAMP_BITS,
   localparam int H  = PixelSensorConfig::PIXEL_ARRAY_HEIGHT,
   localparam int AW = (H > 1) ? $clog2(H) : 1
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   START,
   input  logic                   ABORT,
   input  logic [EXPOSE_BITS-1:0] EXPOSE_TIME,
   input  logic                   ROW_READY,
   output logic                   ERASE,
   output logic                   EXPOSE,
   output logic                   ANALOG_RAMP,
   output logic [RAMP_BITS-1:0]   DIGITAL_RAMP,
   output logic [H-1:0]           READ_ROW,
   output logic [AW-1:0]          ROW_ADDR,
   output logic                   ROW_VALID,
   output logic                   BUSY,
   output logic                   FRAME_DONE
);

   localparam int EW       = $clog2(ERASE_CYCLES) + 1;
   localparam int TW0      = (RAMP_BITS > EXPOSE_BITS) ? RAMP_BITS : EXPOSE_BITS;
   localparam int TW       = (TW0 > EW) ? TW0 : EW;
   localparam int RAMP_MAX = 2 ** RAMP_BITS - 1;

   PixelSensorConfig::ctrl_state_t state, state_n;

   logic [AW-1:0]          row, row_n;
   logic [EXPOSE_BITS-1:0] exp_time, exp_len;
   logic [TW-1:0]          load_val, count, count_next;
   logic                   load, tc, latch, done_n, rd;

   phase_timer #(.WIDTH(TW)) u_timer (
      .clk        (CLK),
      .rst_n      (RESET),
      .load       (load),
      .load_val   (load_val),
      .count      (count),
      .count_next (count_next),
      .tc         (tc)
   );

   assign exp_len = (exp_time == '0) ? EXPOSE_BITS'(1) : exp_time;

   // ABORT overrides everything; in IDLE it also swallows START.
   always_comb begin
      state_n  = state;
      row_n    = row;
      load     = 1'b0;
      load_val = '0;
      latch    = 1'b0;
      done_n   = 1'b0;
      if (ABORT) begin
         state_n = PixelSensorConfig::IDLE;
      end else begin
         case (state)
            PixelSensorConfig::IDLE: begin
               if (START) begin
                  state_n  = PixelSensorConfig::ERASE;
                  latch    = 1'b1;
                  load     = 1'b1;
                  load_val = TW'(ERASE_CYCLES - 1);
               end
            end
            PixelSensorConfig::ERASE: begin
               if (tc) begin
                  state_n  = PixelSensorConfig::EXPOSE;
                  load     = 1'b1;
                  load_val = TW'(exp_len - 1'b1);
               end
            end
            PixelSensorConfig::EXPOSE: begin
               if (tc) begin
                  state_n  = PixelSensorConfig::CONVERT;
                  load     = 1'b1;
                  load_val = TW'(RAMP_MAX);
               end
            end
            PixelSensorConfig::CONVERT: begin
               if (tc) begin
                  state_n = PixelSensorConfig::READOUT;
                  row_n   = '0;
               end
            end
            PixelSensorConfig::READOUT: begin
               if (ROW_READY) begin
                  if (row == AW'(H - 1)) begin
                     state_n = PixelSensorConfig::IDLE;
                     done_n  = 1'b1;
                  end else begin
                     row_n = row + 1'b1;
                  end
               end
            end
            default: state_n = PixelSensorConfig::IDLE;
         endcase
      end
   end

   assign rd = (state_n == PixelSensorConfig::READOUT);

   // Outputs are decoded from next-state so every pin is a flop.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state        <= PixelSensorConfig::IDLE;
         row          <= '0;
         exp_time     <= '0;
         ERASE        <= 1'b0;
         EXPOSE       <= 1'b0;
         ANALOG_RAMP  <= 1'b0;
         DIGITAL_RAMP <= '0;
         READ_ROW     <= '0;
         ROW_ADDR     <= '0;
         ROW_VALID    <= 1'b0;
         BUSY         <= 1'b0;
         FRAME_DONE   <= 1'b0;
      end else begin
         state       <= state_n;
         row         <= row_n;
         if (latch)
            exp_time <= EXPOSE_TIME;
         ERASE       <= (state_n == PixelSensorConfig::ERASE);
         EXPOSE      <= (state_n == PixelSensorConfig::EXPOSE);
         ANALOG_RAMP <= (state_n == PixelSensorConfig::CONVERT);
         DIGITAL_RAMP <= (state_n == PixelSensorConfig::CONVERT)
                       ? RAMP_BITS'(RAMP_MAX) - count_next[RAMP_BITS-1:0]
                       : '0;
         READ_ROW    <= rd ? (H'(1) << row_n) : '0;
         ROW_ADDR    <= rd ? row_n : '0;
         ROW_VALID   <= rd;
         BUSY        <= (state_n != PixelSensorConfig::IDLE);
         FRAME_DONE  <= done_n;
      end
   end

endmodule

// File: doc/pixel_array_controller.md
Name: pixel_array_controller

Overview:
Frame sequencer for the pixel array built from PIXEL_ROW instances. Drives the shared ERASE, EXPOSE, ANALOG_RAMP and DIGITAL_RAMP lines to all rows, then reads rows out one at a time with a one-hot READ select. Each row is presented to a downstream consumer through a valid/ready handshake. It sits between the top-level camera control and the pixel array.

Parameters:
PIXEL_ARRAY_HEIGHT, 2, number of rows; width of READ_ROW. Sourced from the shared package.
ERASE_CYCLES, 5, clock cycles ERASE is held high per frame; must be ≥1.
EXPOSE_BITS, 8, width of EXPOSE_TIME.
RAMP_BITS, 8, DIGITAL_RAMP width; the convert phase lasts 2^RAMP_BITS cycles.

Ports:
CLK  input  1  single clock; all state updates on its rising edge
RESET  input  1  asynchronous, active-low reset
START  input  1  request a frame; sampled only in IDLE
ABORT  input  1  terminate the current frame; return to IDLE
EXPOSE_TIME  input  EXPOSE_BITS  exposure length in cycles; latched on an accepted START
ROW_READY  input  1  consumer accepts the presented row
ERASE  output  1  to all rows
EXPOSE  output  1  to all rows
ANALOG_RAMP  output  1  ramp enable to all rows
DIGITAL_RAMP  output  RAMP_BITS  ramp code to all rows
READ_ROW  output  PIXEL_ARRAY_HEIGHT  one-hot row READ select
ROW_ADDR  output  $clog2(PIXEL_ARRAY_HEIGHT) (min 1)  index of the presented row
ROW_VALID  output  1  row data on the array bus is valid
BUSY  output  1  high in every state except IDLE
FRAME_DONE  output  1  one-cycle pulse on frame completion

Behaviour:
- Reset (RESET=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including DIGITAL_RAMP, READ_ROW and ROW_ADDR.
  - Internal counters are cleared.
  - Deasserting reset does not start a frame.
- States and transitions: IDLE → ERASE → EXPOSE → CONVERT → READOUT → IDLE. All outputs are registered.
- IDLE:
  - START=1 at an edge latches EXPOSE_TIME; ERASE=1 from that edge.
  - A latched EXPOSE_TIME of 0 is treated as 1.
- ERASE: ERASE=1 for exactly ERASE_CYCLES cycles, then EXPOSE.
- EXPOSE: EXPOSE=1 for exactly the latched number of cycles, then CONVERT.
- CONVERT:
  - ANALOG_RAMP=1 for 2^RAMP_BITS cycles.
  - DIGITAL_RAMP=0 in the first cycle and increments by 1 each cycle, reaching 2^RAMP_BITS−1 in the last cycle. No wrap inside the phase.
  - On exit, DIGITAL_RAMP=0 and ANALOG_RAMP=0.
- READOUT:
  - Row index r starts at 0. Outputs are READ_ROW = 1<<r, ROW_ADDR = r, ROW_VALID = 1.
  - ROW_READY=0: all outputs hold and r is unchanged (backpressure, no timeout).
  - ROW_VALID & ROW_READY at an edge, with r < H−1: r increments and the next row is presented in the next cycle, so one row per cycle while ready is held high.
  - Handshake with r = H−1: next cycle is IDLE, READ_ROW=0, ROW_VALID=0, FRAME_DONE=1 for one cycle.
- Phase boundaries: the active output of each phase is never high in the same cycle as another phase's output. ERASE, EXPOSE, ANALOG_RAMP and READ_ROW are mutually exclusive.
- START while BUSY is ignored and not queued. START in the FRAME_DONE cycle is accepted, because the state is already IDLE.
- ABORT=1 at an edge in any non-IDLE state:
  - Next cycle is IDLE with all outputs 0 and no FRAME_DONE.
  - ABORT takes priority over every other transition, including the final READOUT handshake.
  - ABORT in IDLE has no effect; ABORT and START together in IDLE: ABORT wins and START is dropped.
- Frame length with ROW_READY held high: ERASE_CYCLES + max(T,1) + 2^RAMP_BITS + H cycles from the START edge to the FRAME_DONE cycle.

Decomposition:
- Shared package PixelSensorConfig:
  - Existing PIXEL_ARRAY_HEIGHT and PIXEL_BITS.
  - New RAMP_BITS constant and ctrl_state_t enum {IDLE, ERASE, EXPOSE, CONVERT, READOUT}.
- One sub-module, phase_timer:
  - Loadable down-counter with load value, load strobe and a terminal-count flag.
  - Shared by the ERASE, EXPOSE and CONVERT phases.
  - DIGITAL_RAMP is derived as (2^RAMP_BITS−1 − count).

Test Plan:
- Reset mid-CONVERT (DIGITAL_RAMP=0x40), RESET=0 → all outputs 0 immediately without a clock edge; after RESET=1, stays IDLE.
- H=2, ERASE_CYCLES=5, EXPOSE_TIME=10, ROW_READY=1, START pulse → ERASE high 5 cycles; EXPOSE high 10 cycles; ANALOG_RAMP high 256 cycles with DIGITAL_RAMP 0..255; READ_ROW=01 then 10; FRAME_DONE exactly 273 cycles after the START edge.
- Readout backpressure: ROW_READY=0 for 7 cycles on row 0 → READ_ROW=01, ROW_ADDR=0, ROW_VALID=1 stable for 7 cycles; row 1 appears the cycle after ROW_READY=1.
- EXPOSE_TIME=0 → EXPOSE high exactly 1 cycle; EXPOSE_TIME changed mid-frame → no effect on the current frame.
- ABORT during EXPOSE, and separately in the same cycle as the final row handshake → IDLE next cycle, all outputs 0, no FRAME_DONE pulse.
- START held high continuously → back-to-back frames; second ERASE begins the cycle after FRAME_DONE; START pulses while BUSY produce no extra frames.
